// File: rtl/regfile.sv
// 32 x 32 MIPS general-purpose register file: two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward the write-back value to a same-cycle read of that register.
module regfile_rdport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  rst,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] stored,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] data
);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic bypass_hit;
    assign bypass_hit = BYPASS && we && re && (waddr == addr);

    // $0 is checked ahead of the bypass so a discarded write to $0 never leaks out
    always_comb begin
        data = '0;
        if (rst)
            data = '0;
        else if (addr == '0)
            data = '0;
        else if (bypass_hit)
            data = wdata;
        else if (re)
            data = stored;
    end
endmodule

module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] readAddr1,
    output logic [DATA_WIDTH-1:0] regData1,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] readAddr2,
    output logic [DATA_WIDTH-1:0] regData2
);
    localparam int NUM_RD = 2;

    logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_RD-1:0]                  rd_en;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]  rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rd_data;

    assign rd_en    = {re2, re1};
    assign rd_addr  = {readAddr2, readAddr1};
    assign regData1 = rd_data[0];
    assign regData2 = rd_data[1];

    // regs[0] is never written, so it holds the zero loaded at reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs <= '0;
        else if (writeEnable && writeAddr != '0)
            regs[writeAddr] <= writeData;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rdport #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_port (
            .rst   (rst),
            .re    (rd_en[g]),
            .addr  (rd_addr[g]),
            .stored(regs[rd_addr[g]]),
            .we    (writeEnable),
            .waddr (writeAddr),
            .wdata (writeData),
            .data  (rd_data[g])
        );
    end
endmodule
